lsu_align_unit: RTL and testbench
=================================

// Module: lsu_align_unit
// PURPOSE
//  Load/store alignment stage between the EX/MEM register and the word-organised data memory.
//  Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned accesses with byte enables.
//  Splits accesses that straddle a word boundary into two sequential word accesses.
//  Merges, shifts and sign/zero-extends load data; holds the pipeline (req_ready low) while busy.
// PARAMETERS
//  DM_ADDRESS  9   byte-address width of data memory
//  DATA_W      32  data width (only 32 supported)
// PORTS
//  clk         in   1           core clock; all state on rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  req_valid   in   1           request present from EX/MEM
//  req_ready   out  1           unit idle, request accepted when req_valid&&req_ready
//  req_read    in   1           load request (MemRead)
//  req_write   in   1           store request (MemWrite)
//  req_funct3  in   3           instr[14:12]
//  req_addr    in   DM_ADDRESS  byte address (ALU result LSBs)
//  req_wdata   in   DATA_W      store data (rs2)
//  mem_addr    out  DM_ADDRESS  word-aligned address, [1:0]=0
//  mem_re      out  1           memory read strobe
//  mem_we      out  1           memory write strobe
//  mem_be      out  4           byte enables, bit i = byte lane i
//  mem_wdata   out  DATA_W      lane-shifted store data
//  mem_rdata   in   DATA_W      read word, valid the cycle after mem_re
//  resp_valid  out  1           one-cycle completion pulse (loads and stores)
//  resp_rdata  out  DATA_W      extended load data, valid with resp_valid, else 0
//  resp_err    out  1           illegal funct3/opcode combination, valid with resp_valid
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_re/mem_we/mem_be/mem_addr/mem_wdata=0; resp_*=0.
//  FSM IDLE->ACC0->[ACC1]->RESP->IDLE; req_ready=1 only in IDLE.
//  Accept (cycle T): latch read/write/funct3/addr/wdata. Neither read nor write: not accepted.
//  Legal: loads 000,001,010,100,101; stores 000,001,010. Otherwise, or read&&write: IDLE->RESP,
//   resp_valid=1, resp_err=1 at T+1, no memory strobe.
//  Size n=1/2/4 bytes, offset o=addr[1:0]; be8=((1<<n)-1)<<o; split iff be8[7:4]!=0.
//  ACC0 (T+1): mem_addr={addr[DM-1:2],2'b00}, mem_be=be8[3:0], wdata8x={32'b0,wdata}<<(8*o),
//   mem_wdata=low word; mem_re=read, mem_we=write. Split->ACC1 else RESP.
//  ACC1 (T+2): mem_addr=word0+4 modulo 2^DM_ADDRESS (wraps to 0), mem_be=be8[7:4],
//   mem_wdata=high word; capture mem_rdata (word0 data) into lo_q.
//  RESP: loads: d64 = split ? {mem_rdata,lo_q} : {32'b0,mem_rdata}; field=d64>>(8*o);
//   LB/LH sign-extend, LBU/LHU zero-extend, LW full word. resp_valid=1 one cycle.
//  Latency accept->resp_valid: aligned 2, split 3, illegal 1 cycles; throughput 1 request/(latency+1).
//  Strobes and mem_be are 0 outside ACC0/ACC1; mem_re and mem_we never both 1.
//  req_* inputs ignored while not IDLE (latched copy used).
//  Reset mid-operation: immediate return to IDLE, strobes drop asynchronously; a split store
//   interrupted after ACC0 leaves word0 written (no rollback).
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum lsu_state_e, size_bytes() function,
//   legality function is_legal(read,write,funct3).
//  Sub-module lsu_byte_lane (combinational): be8/wdata shift for stores, d64 shift+extend for loads.
//  Top: FSM, request latch, lo_q register, output muxing.
// TESTING
//  SW 0x11223344 @0x010 -> T+1 mem_addr=0x010 be=1111 we=1 wdata=0x11223344; T+2 resp_valid, err=0.
//  LH @0x013, mem[0x010]=0x80FFEEDD, mem[0x014]=0x000000F2 -> two reads 0x010 be=1000, 0x014 be=0001;
//   T+3 resp_rdata=0xFFFFF280; same with LHU -> 0x0000F280.
//  SH 0xABCD @0x1FF (DM_ADDRESS=9) -> ACC0 addr 0x1FC be=1000 wdata=0xCD000000;
//   ACC1 addr 0x000 be=0001 wdata=0x000000AB (wrap).
//  LB @0x002, mem[0x000]=0x00800000 -> resp_rdata=0xFFFFFF80 at T+2; LBU -> 0x00000080.
//  Load funct3=011, and read=write=1 -> resp_valid=1 resp_err=1 at T+1, mem_re/mem_we never asserted.
//  Split SW @0x006, rst_n low during ACC1 -> mem_we=0 same cycle, state IDLE, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/lsu_align_unit_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM states,
// access sizing and legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic is_legal(input logic read, input logic write, input logic [2:0] funct3);
      if (read && write) return 1'b0;
      if (read)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
      if (write)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      return 1'b0;
   endfunction

endpackage

// File: rtl/lsu_align_unit_byte_lane.sv
// Combinational lane steering: byte enables and store data shift across two words,
// load data merge, shift and sign/zero extension.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] lo_i,
   output logic [7:0]  be8_o,
   output logic        split_o,
   output logic [63:0] wdata64_o,
   output logic [31:0] load_o
);

   logic [3:0]  n;
   logic [3:0]  mask4;
   logic [4:0]  sh;
   logic [63:0] d64;
   logic [31:0] field;

   always_comb begin
      n         = size_bytes(funct3_i);
      mask4     = (n == 4'd1) ? 4'b0001 : (n == 4'd2) ? 4'b0011 : 4'b1111;
      sh        = {offset_i, 3'b000};
      be8_o     = {4'b0000, mask4} << offset_i;
      split_o   = |be8_o[7:4];
      wdata64_o = {32'b0, wdata_i} << sh;
      // word0 was captured into lo_i on the previous cycle; rdata_i is the last word read
      d64       = split_o ? {rdata_i, lo_i} : {32'b0, rdata_i};
      field     = 32'(d64 >> sh);
      case (funct3_i)
         F3_B:    load_o = {{24{field[7]}}, field[7:0]};
         F3_H:    load_o = {{16{field[15]}}, field[15:0]};
         F3_BU:   load_o = {24'b0, field[7:0]};
         F3_HU:   load_o = {16'b0, field[15:0]};
         default: load_o = field;
      endcase
   end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment stage: turns byte-addressed requests into one or two word
// accesses with byte enables, and returns extended load data with a completion pulse.
module lsu_align_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   lsu_state_e            state_q, state_d;
   logic                  accept;
   logic                  read_q, write_q, err_q;
   logic [2:0]            f3_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     lo_q;

   logic [7:0]            be8;
   logic                  split;
   logic [63:0]           wdata64;
   logic [31:0]           load_data;
   logic [DM_ADDRESS-1:0] word0, word1;

   lsu_byte_lane u_lane (
      .funct3_i  (f3_q),
      .offset_i  (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (mem_rdata),
      .lo_i      (lo_q),
      .be8_o     (be8),
      .split_o   (split),
      .wdata64_o (wdata64),
      .load_o    (load_data)
   );

   assign word0 = {addr_q[DM_ADDRESS-1:2], 2'b00};
   assign word1 = word0 + DM_ADDRESS'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
      end else begin
         if (accept) begin
            read_q  <= req_read;
            write_q <= req_write;
            err_q   <= !is_legal(req_read, req_write, req_funct3);
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == ST_ACC1) lo_q <= mem_rdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      req_ready  = 1'b0;
      mem_addr   = '0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && (req_read || req_write)) begin
               accept  = 1'b1;
               state_d = is_legal(req_read, req_write, req_funct3) ? ST_ACC0 : ST_RESP;
            end
         end
         ST_ACC0: begin
            mem_addr  = word0;
            mem_be    = be8[3:0];
            mem_wdata = wdata64[31:0];
            mem_re    = read_q;
            mem_we    = write_q;
            state_d   = split ? ST_ACC1 : ST_RESP;
         end
         ST_ACC1: begin
            mem_addr  = word1;
            mem_be    = be8[7:4];
            mem_wdata = wdata64[63:32];
            mem_re    = read_q;
            mem_we    = write_q;
            state_d   = ST_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (read_q && !err_q) ? load_data : '0;
            state_d    = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit with a byte-enabled word memory model and
// scoreboards for memory accesses and responses.
module tb_lsu_align_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [8:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [8:0]  mem_addr;
   logic        mem_re, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct { logic re; logic we; logic [8:0] addr; logic [3:0] be; logic [31:0] wdata; } acc_t;
   typedef struct { logic [31:0] rdata; logic err; } rsp_t;
   acc_t acc_q[$];
   rsp_t rsp_q[$];

   logic [31:0] mem [0:127] = '{default: '0};

   lsu_align_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_acc(input logic re, input logic we, input logic [8:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
      acc_t x;
      x.re = re; x.we = we; x.addr = a; x.be = be; x.wdata = wd;
      acc_q.push_back(x);
   endtask

   task automatic push_rsp(input logic [31:0] rd, input logic err);
      rsp_t x;
      x.rdata = rd; x.err = err;
      rsp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_re || mem_we || mem_be != 4'b0000) begin
            chk("excl", {63'b0, mem_re & mem_we}, 64'd0);
            if (acc_q.size() == 0) begin
               chk("acc_unexp", {55'b0, mem_re, mem_we, mem_be, 3'b0}, 64'd0);
            end else begin
               acc_t a;
               a = acc_q.pop_front();
               chk("acc_re", {63'b0, mem_re}, {63'b0, a.re});
               chk("acc_we", {63'b0, mem_we}, {63'b0, a.we});
               chk("acc_addr", {55'b0, mem_addr}, {55'b0, a.addr});
               chk("acc_be", {60'b0, mem_be}, {60'b0, a.be});
               if (a.we) chk("acc_wdata", {32'b0, mem_wdata}, {32'b0, a.wdata});
            end
         end
         if (resp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("resp_unexp", {63'b0, resp_valid}, 64'd0);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("resp_rdata", {32'b0, resp_rdata}, {32'b0, r.rdata});
               chk("resp_err", {63'b0, resp_err}, {63'b0, r.err});
            end
         end
      end
   end

   task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] wd, input int lat);
      int t0;
      @(negedge clk);
      chk("ready_idle", {63'b0, req_ready}, 64'd1);
      req_valid = 1'b1; req_read = r; req_write = w; req_funct3 = f3;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      t0 = cyc;
      #1;
      // scramble request inputs so only the latched copy can produce the right result
      req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
      req_funct3 = 3'($urandom); req_addr = 9'($urandom); req_wdata = $urandom;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid) break;
      end
      chk("latency", 64'(cyc - t0), 64'(lat));
   endtask

   initial begin
      #2;
      chk("rst_ready", {63'b0, req_ready}, 64'd1);
      chk("rst_strobes", {58'b0, mem_re, mem_we, mem_be}, 64'd0);
      chk("rst_addr", {55'b0, mem_addr}, 64'd0);
      chk("rst_wdata", {32'b0, mem_wdata}, 64'd0);
      chk("rst_resp", {31'b0, resp_valid, resp_err, resp_rdata}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      push_acc(0, 1, 9'h010, 4'b1111, 32'h11223344); push_rsp(32'h0, 0);
      issue(0, 1, F3_W, 9'h010, 32'h11223344, 2);
      chk("mem_sw", {32'b0, mem[4]}, 64'h11223344);

      push_acc(0, 1, 9'h010, 4'b1111, 32'h80FFEEDD); push_rsp(32'h0, 0);
      issue(0, 1, F3_W, 9'h010, 32'h80FFEEDD, 2);
      push_acc(0, 1, 9'h014, 4'b1111, 32'h000000F2); push_rsp(32'h0, 0);
      issue(0, 1, F3_W, 9'h014, 32'h000000F2, 2);

      push_acc(1, 0, 9'h010, 4'b1000, 32'h0); push_acc(1, 0, 9'h014, 4'b0001, 32'h0);
      push_rsp(32'hFFFFF280, 0);
      issue(1, 0, F3_H, 9'h013, 32'h0, 3);
      push_acc(1, 0, 9'h010, 4'b1000, 32'h0); push_acc(1, 0, 9'h014, 4'b0001, 32'h0);
      push_rsp(32'h0000F280, 0);
      issue(1, 0, F3_HU, 9'h013, 32'h0, 3);

      push_acc(1, 0, 9'h010, 4'b1100, 32'h0); push_acc(1, 0, 9'h014, 4'b0011, 32'h0);
      push_rsp(32'h00F280FF, 0);
      issue(1, 0, F3_W, 9'h012, 32'h0, 3);

      push_acc(0, 1, 9'h1FC, 4'b1000, 32'hCD000000); push_acc(0, 1, 9'h000, 4'b0001, 32'h000000AB);
      push_rsp(32'h0, 0);
      issue(0, 1, F3_H, 9'h1FF, 32'h0000ABCD, 3);
      chk("mem_wrap_lo", {32'b0, mem[0]}, 64'h000000AB);
      chk("mem_wrap_hi", {32'b0, mem[127]}, 64'hCD000000);

      push_acc(0, 1, 9'h000, 4'b1111, 32'h00800000); push_rsp(32'h0, 0);
      issue(0, 1, F3_W, 9'h000, 32'h00800000, 2);
      push_acc(1, 0, 9'h000, 4'b0100, 32'h0); push_rsp(32'hFFFFFF80, 0);
      issue(1, 0, F3_B, 9'h002, 32'h0, 2);
      push_acc(1, 0, 9'h000, 4'b0100, 32'h0); push_rsp(32'h00000080, 0);
      issue(1, 0, F3_BU, 9'h002, 32'h0, 2);

      push_acc(0, 1, 9'h00C, 4'b0010, 32'h34565A00); push_rsp(32'h0, 0);
      issue(0, 1, F3_B, 9'h00D, 32'h1234565A, 2);
      chk("mem_sb", {32'b0, mem[3]}, 64'h00005A00);

      push_rsp(32'h0, 1);
      issue(1, 0, 3'b011, 9'h010, 32'h0, 1);
      push_rsp(32'h0, 1);
      issue(1, 1, F3_W, 9'h010, 32'h0, 1);
      push_rsp(32'h0, 1);
      issue(0, 1, F3_BU, 9'h010, 32'h0, 1);

      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_funct3 = F3_W; req_addr = 9'h010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("noop_ready", {63'b0, req_ready}, 64'd1);
         chk("noop_resp", {63'b0, resp_valid}, 64'd0);
      end
      req_valid = 1'b0;

      push_acc(0, 1, 9'h004, 4'b1100, 32'hC3D40000);
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = F3_W;
      req_addr = 9'h006; req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("acc1_we", {63'b0, mem_we}, 64'd1);
      chk("acc1_addr", {55'b0, mem_addr}, 64'h008);
      rst_n = 1'b0;
      #1;
      chk("arst_we", {63'b0, mem_we}, 64'd0);
      chk("arst_be", {60'b0, mem_be}, 64'd0);
      chk("arst_ready", {63'b0, req_ready}, 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("arst_resp", {63'b0, resp_valid}, 64'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_resp_idle", {63'b0, resp_valid}, 64'd0);
      chk("arst_ready_idle", {63'b0, req_ready}, 64'd1);
      chk("mem_word0_kept", {32'b0, mem[1]}, 64'hC3D40000);
      chk("mem_word1_untouched", {32'b0, mem[2]}, 64'h0);

      chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
      chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
